// File: rtl/window_line_controller_if.sv
// Pixel-source stream into the window line controller.
//   v_sync    : frame-start pulse (1 cycle)
//   h_sync    : line-start pulse (1 cycle)
//   pix_valid : pix_in carries a pixel this cycle
//   pix_in    : 8-bit source pixel
//   pix_ready : controller accepts pix_in when pix_valid & pix_ready
// master = pixel source, slave = controller.
interface window_line_controller_if;
    logic       v_sync;
    logic       h_sync;
    logic       pix_valid;
    logic [7:0] pix_in;
    logic       pix_ready;

    modport master (
        output v_sync,
        output h_sync,
        output pix_valid,
        output pix_in,
        input  pix_ready
    );

    modport slave (
        input  v_sync,
        input  h_sync,
        input  pix_valid,
        input  pix_in,
        output pix_ready
    );
endinterface

// File: rtl/window_line_controller.sv
// Sequences a WIN-tap pixel shift register for raster-scan filtering.
// Clears the register at each line start, feeds accepted pixels, pads HALF
// zeros at the line end and flags every shift whose centre tap is a real
// column, so each line yields exactly IMG_W windows.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   pix         : pixel stream (v_sync/h_sync framing, valid/ready handshake)
//   sr_clr      : synchronous clear to the shift register
//   sr_en       : shift enable to the shift register
//   sr_data     : data into the shift register
//   win_valid   : shift-register window is a centred window this cycle
//   win_col     : centre-tap column of the window
//   win_row     : row of the window
//   line_done   : pulse with the last window of a line
//   frame_done  : pulse with the last window of a frame
//   line_err    : pulse when a line is aborted early
module window_line_controller #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned WIN   = 5,
    parameter int unsigned CW    = $clog2(IMG_W),
    parameter int unsigned RW    = $clog2(IMG_H)
) (
    input  logic                     clk,
    input  logic                     rst,
    window_line_controller_if.slave  pix,
    output logic                     sr_clr,
    output logic                     sr_en,
    output logic [7:0]               sr_data,
    output logic                     win_valid,
    output logic [CW-1:0]            win_col,
    output logic [RW-1:0]            win_row,
    output logic                     line_done,
    output logic                     frame_done,
    output logic                     line_err
);

    localparam int unsigned HALF  = WIN / 2;
    localparam int unsigned K_MAX = IMG_W - 1 + HALF;
    localparam int unsigned KW    = $clog2(K_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_LINE,
        S_FILL,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic [RW-1:0] row;
    logic          hs_pend;

    // Stage 1: describes the shift issued on sr_en this cycle
    logic          s1_win;
    logic          s1_last;
    logic          s1_frame;
    logic [CW-1:0] s1_col;
    logic [RW-1:0] s1_row;

    logic          accept_c;
    logic          centred_c;
    logic          last_pix_c;
    logic          last_pad_c;
    logic          last_row_c;
    logic          to_run_c;
    logic          in_line_c;
    logic [KW-1:0] k_inc_c;
    logic [CW-1:0] col_c;

    assign accept_c   = pix.pix_valid & pix.pix_ready;
    assign k_inc_c    = k + KW'(1);
    assign centred_c  = (k >= KW'(HALF));
    assign col_c      = CW'(k - KW'(HALF));
    assign last_pix_c = (k == KW'(IMG_W - 1));
    assign last_pad_c = (k == KW'(K_MAX));
    assign last_row_c = (row == RW'(IMG_H - 1));
    assign to_run_c   = (k_inc_c == KW'(HALF));
    assign in_line_c  = (state == S_FILL) || (state == S_RUN) || (state == S_DRAIN);

    // Line sequencer with a two-stage window pipeline (shift issue, window out)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            k             <= '0;
            row           <= '0;
            hs_pend       <= 1'b0;
            s1_win        <= 1'b0;
            s1_last       <= 1'b0;
            s1_frame      <= 1'b0;
            s1_col        <= '0;
            s1_row        <= '0;
            pix.pix_ready <= 1'b0;
            sr_clr        <= 1'b1;
            sr_en         <= 1'b0;
            sr_data       <= '0;
            win_valid     <= 1'b0;
            win_col       <= '0;
            win_row       <= '0;
            line_done     <= 1'b0;
            frame_done    <= 1'b0;
            line_err      <= 1'b0;
        end else begin
            sr_clr     <= 1'b0;
            sr_en      <= 1'b0;
            line_err   <= 1'b0;
            s1_win     <= 1'b0;
            s1_last    <= 1'b0;
            s1_frame   <= 1'b0;
            // The register output lags sr_en by one edge; windows follow stage 1
            win_valid  <= s1_win;
            win_col    <= s1_col;
            win_row    <= s1_row;
            line_done  <= s1_win & s1_last;
            frame_done <= s1_win & s1_frame;

            if (pix.v_sync) begin
                // Frame restart wins over everything, including a same-cycle h_sync
                line_err      <= in_line_c;
                state         <= S_WAIT_LINE;
                row           <= '0;
                k             <= '0;
                hs_pend       <= 1'b0;
                pix.pix_ready <= 1'b0;
                win_valid     <= 1'b0;
                line_done     <= 1'b0;
                frame_done    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        pix.pix_ready <= 1'b0;
                    end

                    S_WAIT_LINE: begin
                        if (pix.h_sync) begin
                            sr_clr        <= 1'b1;
                            k             <= '0;
                            state         <= S_FILL;
                            pix.pix_ready <= 1'b1;
                        end
                    end

                    S_FILL, S_RUN: begin
                        if (pix.h_sync) begin
                            // Early line restart: drop windows still in the pipe
                            line_err      <= 1'b1;
                            sr_clr        <= 1'b1;
                            k             <= '0;
                            state         <= S_FILL;
                            pix.pix_ready <= 1'b1;
                            win_valid     <= 1'b0;
                            line_done     <= 1'b0;
                            frame_done    <= 1'b0;
                        end else if (accept_c) begin
                            sr_en   <= 1'b1;
                            sr_data <= pix.pix_in;
                            s1_win  <= centred_c;
                            s1_col  <= col_c;
                            s1_row  <= row;
                            k       <= k_inc_c;
                            if (last_pix_c) begin
                                state         <= S_DRAIN;
                                pix.pix_ready <= 1'b0;
                            end else if (to_run_c) begin
                                state <= S_RUN;
                            end
                        end
                    end

                    S_DRAIN: begin
                        // Right padding: every pad is a centred window
                        sr_en    <= 1'b1;
                        sr_data  <= '0;
                        s1_win   <= 1'b1;
                        s1_col   <= col_c;
                        s1_row   <= row;
                        s1_last  <= last_pad_c;
                        s1_frame <= last_pad_c & last_row_c;
                        if (pix.h_sync) begin
                            hs_pend <= 1'b1;
                        end
                        if (!last_pad_c) begin
                            k <= k_inc_c;
                        end else if (last_row_c) begin
                            row     <= '0;
                            hs_pend <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            row <= row + RW'(1);
                            if (hs_pend || pix.h_sync) begin
                                // A line start seen during the drain opens the next line now
                                hs_pend       <= 1'b0;
                                sr_clr        <= 1'b1;
                                k             <= '0;
                                state         <= S_FILL;
                                pix.pix_ready <= 1'b1;
                            end else begin
                                state <= S_WAIT_LINE;
                            end
                        end
                    end

                    default: begin
                        state         <= S_IDLE;
                        pix.pix_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_window_line_controller.sv
// Directed bench for window_line_controller (IMG_W=8, IMG_H=3, WIN=5).
module tb_window_line_controller;

    localparam int unsigned IMG_W = 8;
    localparam int unsigned IMG_H = 3;
    localparam int unsigned WIN   = 5;
    localparam int unsigned CW    = 3;
    localparam int unsigned RW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          sr_clr;
    logic          sr_en;
    logic [7:0]    sr_data;
    logic          win_valid;
    logic [CW-1:0] win_col;
    logic [RW-1:0] win_row;
    logic          line_done;
    logic          frame_done;
    logic          line_err;

    window_line_controller_if bus();

    window_line_controller #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .WIN   (WIN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix        (bus),
        .sr_clr     (sr_clr),
        .sr_en      (sr_en),
        .sr_data    (sr_data),
        .win_valid  (win_valid),
        .win_col    (win_col),
        .win_row    (win_row),
        .line_done  (line_done),
        .frame_done (frame_done),
        .line_err   (line_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int p3    = 0;
    int sr_q[$];
    int wc_q[$];
    int wr_q[$];
    int wcyc_q[$];
    int ld_q[$];
    int fd_q[$];
    int err_n = 0;
    int clr_n = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic log_clear();
        sr_q.delete();
        wc_q.delete();
        wr_q.delete();
        wcyc_q.delete();
        ld_q.delete();
        fd_q.delete();
        err_n = 0;
        clr_n = 0;
    endtask

    // Apply inputs for one cycle, then sample and log outputs 1 ns after the edge
    task automatic drive(input logic v, input logic h, input logic pv, input logic [7:0] px);
        bus.v_sync    = v;
        bus.h_sync    = h;
        bus.pix_valid = pv;
        bus.pix_in    = px;
        @(posedge clk);
        #1;
        cyc++;
        if (sr_en) sr_q.push_back(int'(sr_data));
        if (win_valid) begin
            wc_q.push_back(int'(win_col));
            wr_q.push_back(int'(win_row));
            wcyc_q.push_back(cyc);
        end
        if (line_done)  ld_q.push_back(win_valid ? int'(win_col) : -1);
        if (frame_done) fd_q.push_back(win_valid ? int'(win_col) * 10 + int'(win_row) : -1);
        if (line_err) err_n++;
        if (sr_clr)   clr_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic run_line(input int base);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, 8'(base + i));
        idle(6);
    endtask

    // Shift sequence: npix pixels base.. followed by npad zeros
    task automatic chk_sr(input string tag, input int base, input int npix, input int npad);
        chk($sformatf("%s shift count", tag), sr_q.size(), npix + npad);
        foreach (sr_q[i])
            chk($sformatf("%s shift%0d", tag, i), sr_q[i], (i < npix) ? base + i : 0);
    endtask

    // Windows: n windows with columns 0..n-1, all on the given row
    task automatic chk_win(input string tag, input int n, input int row);
        chk($sformatf("%s win count", tag), wc_q.size(), n);
        foreach (wc_q[i]) begin
            chk($sformatf("%s win%0d col", tag, i), wc_q[i], i);
            chk($sformatf("%s win%0d row", tag, i), wr_q[i], row);
        end
    endtask

    initial begin
        rst           = 1'b0;
        bus.v_sync    = 1'b0;
        bus.h_sync    = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_in    = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk1("rst sr_clr", sr_clr, 1'b1);
        chk1("rst sr_en", sr_en, 1'b0);
        chk("rst sr_data", 32'(sr_data), 0);
        chk1("rst win_valid", win_valid, 1'b0);
        chk1("rst pix_ready", bus.pix_ready, 1'b0);
        chk1("rst line_done", line_done, 1'b0);
        chk1("rst frame_done", frame_done, 1'b0);
        chk1("rst line_err", line_err, 1'b0);
        rst = 1'b1;
        #1;
        chk1("release sr_clr held", sr_clr, 1'b1);
        idle(1);
        chk1("release sr_clr fall", sr_clr, 1'b0);
        chk1("release pix_ready", bus.pix_ready, 1'b0);

        // Line 0: back-to-back pixels 1..8
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        chk1("vsync pix_ready", bus.pix_ready, 1'b0);
        log_clear();
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        chk1("hsync sr_clr", sr_clr, 1'b1);
        chk1("hsync pix_ready", bus.pix_ready, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) p3 = cyc;
            drive(1'b0, 1'b0, 1'b1, 8'(i));
        end
        idle(6);
        chk_sr("l0", 1, 8, 2);
        chk_win("l0", 8, 0);
        chk("l0 first window latency", (wcyc_q.size() > 0) ? wcyc_q[0] - p3 : -1, 2);
        chk("l0 line_done count", ld_q.size(), 1);
        chk("l0 line_done col", (ld_q.size() > 0) ? ld_q[0] : -1, 7);
        chk("l0 frame_done count", fd_q.size(), 0);
        chk("l0 sr_clr count", clr_n, 1);

        // Lines 1 and 2 complete the frame
        log_clear();
        run_line(101);
        chk_sr("l1", 101, 8, 2);
        chk_win("l1", 8, 1);
        chk("l1 frame_done count", fd_q.size(), 0);
        log_clear();
        run_line(201);
        chk_sr("l2", 201, 8, 2);
        chk_win("l2", 8, 2);
        chk("l2 line_done col", (ld_q.size() > 0) ? ld_q[0] : -1, 7);
        chk("l2 frame_done count", fd_q.size(), 1);
        chk("l2 frame_done col*10+row", (fd_q.size() > 0) ? fd_q[0] : -1, 72);
        // Back in IDLE: h_sync alone must not start a line
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        chk1("idle hsync sr_clr", sr_clr, 1'b0);
        chk1("idle hsync pix_ready", bus.pix_ready, 1'b0);

        // Gapped input: pix_valid 1-0-1
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        log_clear();
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(i));
            drive(1'b0, 1'b0, 1'b0, 8'hAA);
        end
        idle(4);
        chk_sr("gap", 1, 8, 2);
        chk_win("gap", 8, 0);
        for (int i = 0; i < 5; i++)
            chk($sformatf("gap spacing%0d", i),
                (wcyc_q.size() > i + 1) ? wcyc_q[i + 1] - wcyc_q[i] : -1, 2);

        // h_sync after 4 pixels aborts and restarts the line on the same row
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 1; i <= 4; i++) drive(1'b0, 1'b0, 1'b1, 8'(i));
        log_clear();
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        chk1("abort line_err", line_err, 1'b1);
        chk1("abort sr_clr", sr_clr, 1'b1);
        chk1("abort win_valid", win_valid, 1'b0);
        chk1("abort pix_ready", bus.pix_ready, 1'b1);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, 8'(11 + i));
        idle(6);
        chk_sr("restart", 11, 8, 2);
        chk_win("restart", 8, 0);
        chk("restart line_err count", err_n, 1);

        // v_sync during DRAIN suppresses remaining pads and resets the row
        log_clear();
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, 8'(21 + i));
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        chk1("drain vsync line_err", line_err, 1'b1);
        chk1("drain vsync win_valid", win_valid, 1'b0);
        idle(4);
        chk_sr("drain abort", 21, 8, 1);
        chk_win("drain abort", 6, 1);
        chk("drain abort line_done count", ld_q.size(), 0);
        chk("drain abort line_err count", err_n, 1);
        log_clear();
        run_line(31);
        chk_sr("after vsync", 31, 8, 2);
        chk_win("after vsync", 8, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
